// File: rtl/alu.sv
// 8-bit registered ALU: 32 operations selected by i_select, result and Z/C flags captured
// on the rising edge when i_op_enable is high; the stored carry feeds ADC/SBB/RCL/RCR.
module alu (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_op_enable,
    input  logic [4:0] i_select,
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    output logic [7:0] o_out,
    output logic       o_flag_zero,
    output logic       o_flag_carry
);

    localparam logic [4:0] OpPassA = 5'h00, OpAdd  = 5'h01, OpAdc  = 5'h02, OpSub  = 5'h03;
    localparam logic [4:0] OpSbb   = 5'h04, OpInc  = 5'h05, OpDec  = 5'h06, OpAnd  = 5'h07;
    localparam logic [4:0] OpOr    = 5'h08, OpXor  = 5'h09, OpNot  = 5'h0A, OpNand = 5'h0B;
    localparam logic [4:0] OpNor   = 5'h0C, OpXnor = 5'h0D, OpShl  = 5'h0E, OpShr  = 5'h0F;
    localparam logic [4:0] OpAsr   = 5'h10, OpRol  = 5'h11, OpRor  = 5'h12, OpRcl  = 5'h13;
    localparam logic [4:0] OpRcr   = 5'h14, OpCmp  = 5'h15, OpPassB = 5'h16, OpNeg = 5'h17;
    localparam logic [4:0] OpSwap  = 5'h18, OpClr  = 5'h19, OpSet  = 5'h1A, OpMin  = 5'h1B;
    localparam logic [4:0] OpMax   = 5'h1C, OpMul  = 5'h1D, OpTst  = 5'h1E, OpNop  = 5'h1F;

    logic [7:0]  r_out;
    logic        r_zero;
    logic        r_carry;

    logic [8:0]  w_add;
    logic [8:0]  w_adc;
    logic [8:0]  w_sub;
    logic [8:0]  w_sbb;
    logic [15:0] w_mul;
    logic [7:0]  w_res;
    logic        w_carry;
    logic        w_wr_out;
    logic        w_wr_flags;

    // 9-bit forms: bit 8 is carry for sums and borrow for differences
    assign w_add = {1'b0, i_a} + {1'b0, i_b};
    assign w_adc = w_add + {8'h00, r_carry};
    assign w_sub = {1'b0, i_a} - {1'b0, i_b};
    assign w_sbb = w_sub - {8'h00, r_carry};
    assign w_mul = {8'h00, i_a} * {8'h00, i_b};

    always_comb begin
        w_res      = 8'h00;
        w_carry    = 1'b0;
        w_wr_out   = 1'b1;
        w_wr_flags = 1'b1;
        case (i_select)
            OpPassA: w_res = i_a;
            OpAdd:   begin w_res = w_add[7:0]; w_carry = w_add[8]; end
            OpAdc:   begin w_res = w_adc[7:0]; w_carry = w_adc[8]; end
            OpSub:   begin w_res = w_sub[7:0]; w_carry = w_sub[8]; end
            OpSbb:   begin w_res = w_sbb[7:0]; w_carry = w_sbb[8]; end
            OpInc:   begin w_res = i_a + 8'h01; w_carry = (i_a == 8'hFF); end
            OpDec:   begin w_res = i_a - 8'h01; w_carry = (i_a == 8'h00); end
            OpAnd:   w_res = i_a & i_b;
            OpOr:    w_res = i_a | i_b;
            OpXor:   w_res = i_a ^ i_b;
            OpNot:   w_res = ~i_a;
            OpNand:  w_res = ~(i_a & i_b);
            OpNor:   w_res = ~(i_a | i_b);
            OpXnor:  w_res = ~(i_a ^ i_b);
            OpShl:   begin w_res = {i_a[6:0], 1'b0};     w_carry = i_a[7]; end
            OpShr:   begin w_res = {1'b0, i_a[7:1]};     w_carry = i_a[0]; end
            OpAsr:   begin w_res = {i_a[7], i_a[7:1]};   w_carry = i_a[0]; end
            OpRol:   begin w_res = {i_a[6:0], i_a[7]};   w_carry = i_a[7]; end
            OpRor:   begin w_res = {i_a[0], i_a[7:1]};   w_carry = i_a[0]; end
            OpRcl:   begin w_res = {i_a[6:0], r_carry};  w_carry = i_a[7]; end
            OpRcr:   begin w_res = {r_carry, i_a[7:1]};  w_carry = i_a[0]; end
            OpCmp:   begin w_res = w_sub[7:0]; w_carry = w_sub[8]; w_wr_out = 1'b0; end
            OpPassB: w_res = i_b;
            OpNeg:   begin w_res = 8'h00 - i_a; w_carry = (i_a != 8'h00); end
            OpSwap:  w_res = {i_a[3:0], i_a[7:4]};
            OpClr:   w_res = 8'h00;
            OpSet:   w_res = 8'hFF;
            OpMin:   w_res = (i_a < i_b) ? i_a : i_b;
            OpMax:   w_res = (i_a > i_b) ? i_a : i_b;
            OpMul:   begin w_res = w_mul[7:0]; w_carry = |w_mul[15:8]; end
            OpTst:   begin w_res = i_a & i_b; w_wr_out = 1'b0; end
            OpNop:   begin w_wr_out = 1'b0; w_wr_flags = 1'b0; end
            default: begin w_wr_out = 1'b0; w_wr_flags = 1'b0; end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out   <= 8'h00;
            r_zero  <= 1'b1;
            r_carry <= 1'b0;
        end else if (i_op_enable) begin
            if (w_wr_out) begin
                r_out <= w_res;
            end
            if (w_wr_flags) begin
                r_zero  <= (w_res == 8'h00);
                r_carry <= w_carry;
            end
        end
    end

    assign o_out        = r_out;
    assign o_flag_zero  = r_zero;
    assign o_flag_carry = r_carry;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: reset, worked examples, carry chaining, full opcode
// sweep with A=CB B=14, enable-low hold and mid-sweep reset.
module tb_alu;

    logic       clk;
    logic       rst;
    logic       en;
    logic [4:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;
    logic       fz;
    logic       fc;

    int n_checks = 0;
    int n_errors = 0;

    alu u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_op_enable  (en),
        .i_select     (sel),
        .i_a          (a),
        .i_b          (b),
        .o_out        (out),
        .o_flag_zero  (fz),
        .o_flag_carry (fc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got {out,z,c}=%h_%b_%b expected %h_%b_%b", tag,
                     got[9:2], got[1], got[0], exp[9:2], exp[1], exp[0]);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge
    task automatic step(input logic r, input logic e, input logic [4:0] s,
                        input logic [7:0] va, input logic [7:0] vb);
        rst = r;
        en  = e;
        sel = s;
        a   = va;
        b   = vb;
        @(posedge clk);
        #1;
    endtask

    task automatic op_check(input string tag, input logic [4:0] s, input logic [7:0] va,
                            input logic [7:0] vb, input logic [9:0] exp);
        step(1'b0, 1'b1, s, va, vb);
        check_eq(tag, {out, fz, fc}, exp);
    endtask

    // Expected {out, Z, C} after each sweep step, A=CB B=14, starting from reset state
    logic [9:0] sweep_exp [32];

    initial begin
        sweep_exp = '{
            {8'hCB, 2'b00}, {8'hDF, 2'b00}, {8'hDF, 2'b00}, {8'hB7, 2'b00},
            {8'hB7, 2'b00}, {8'hCC, 2'b00}, {8'hCA, 2'b00}, {8'h00, 2'b10},
            {8'hDF, 2'b00}, {8'hDF, 2'b00}, {8'h34, 2'b00}, {8'hFF, 2'b00},
            {8'h20, 2'b00}, {8'h20, 2'b00}, {8'h96, 2'b01}, {8'h65, 2'b01},
            {8'hE5, 2'b01}, {8'h97, 2'b01}, {8'hE5, 2'b01}, {8'h97, 2'b01},
            {8'hE5, 2'b01}, {8'hE5, 2'b00}, {8'h14, 2'b00}, {8'h35, 2'b01},
            {8'hBC, 2'b00}, {8'h00, 2'b10}, {8'hFF, 2'b00}, {8'h14, 2'b00},
            {8'hCB, 2'b00}, {8'hDC, 2'b01}, {8'hDC, 2'b10}, {8'hDC, 2'b10}
        };

        step(1'b1, 1'b1, 5'h01, 8'h55, 8'hAA);
        check_eq("reset", {out, fz, fc}, {8'h00, 2'b10});

        op_check("add_cb_14", 5'h01, 8'hCB, 8'h14, {8'hDF, 2'b00});
        op_check("sub_cb_14", 5'h03, 8'hCB, 8'h14, {8'hB7, 2'b00});
        op_check("and_cb_14", 5'h07, 8'hCB, 8'h14, {8'h00, 2'b10});
        op_check("rcl_cin0",  5'h13, 8'hCB, 8'h14, {8'h96, 2'b01});
        op_check("rcr_cin1",  5'h14, 8'hCB, 8'h14, {8'hE5, 2'b01});
        op_check("shl_cb",    5'h0E, 8'hCB, 8'h14, {8'h96, 2'b01});
        op_check("ror_cb",    5'h12, 8'hCB, 8'h14, {8'hE5, 2'b01});
        op_check("mul_cb_14", 5'h1D, 8'hCB, 8'h14, {8'hDC, 2'b01});

        op_check("add_ff_01", 5'h01, 8'hFF, 8'h01, {8'h00, 2'b11});
        op_check("adc_cin1",  5'h02, 8'h00, 8'h00, {8'h01, 2'b00});
        op_check("sub_borrow", 5'h03, 8'h00, 8'h01, {8'hFF, 2'b01});
        op_check("sbb_cin1",  5'h04, 8'h05, 8'h02, {8'h02, 2'b00});
        op_check("sbb_borrow", 5'h04, 8'h00, 8'h00, {8'h00, 2'b10});
        op_check("inc_ff",    5'h05, 8'hFF, 8'h00, {8'h00, 2'b11});
        op_check("dec_00",    5'h06, 8'h00, 8'h00, {8'hFF, 2'b01});
        op_check("rcr_cin1b", 5'h14, 8'h02, 8'h00, {8'h81, 2'b00});
        op_check("rcr_cin0",  5'h14, 8'h02, 8'h00, {8'h01, 2'b00});
        op_check("neg_00",    5'h17, 8'h00, 8'h00, {8'h00, 2'b10});
        op_check("min_lt",    5'h1B, 8'h03, 8'h09, {8'h03, 2'b00});
        op_check("max_lt",    5'h1C, 8'h03, 8'h09, {8'h09, 2'b00});
        op_check("mul_small", 5'h1D, 8'h0F, 8'h11, {8'hFF, 2'b00});

        step(1'b1, 1'b0, 5'h00, 8'h00, 8'h00);
        check_eq("reset2", {out, fz, fc}, {8'h00, 2'b10});
        for (int i = 0; i < 32; i++) begin
            op_check($sformatf("sweep_%02h", i), 5'(i), 8'hCB, 8'h14, sweep_exp[i]);
        end

        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 5'(i * 5 + 1), 8'(i * 37 + 1), 8'(i * 11));
            check_eq($sformatf("hold_%0d", i), {out, fz, fc}, {8'hDC, 2'b10});
        end

        op_check("pre_rst",   5'h0A, 8'hCB, 8'h14, {8'h34, 2'b00});
        op_check("pre_rst_c", 5'h0E, 8'hCB, 8'h14, {8'h96, 2'b01});
        step(1'b1, 1'b1, 5'h1A, 8'hCB, 8'h14);
        check_eq("mid_rst", {out, fz, fc}, {8'h00, 2'b10});
        op_check("post_rst", 5'h1A, 8'hCB, 8'h14, {8'hFF, 2'b00});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
